seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector with a runtime-loadable pattern, length and overlap mode, a Mealy match output and a saturating match counter. It generalises the fixed 4-bit overlapping detector. With default parameters it comes out of reset detecting 1011 with overlap, and its match output behaves identically to the fixed 4-bit overlapping detector. It sits on a serial input stream and feeds event/interrupt logic through match, match_q and match_count.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2)
- CNT_W, 16: match counter width
- DEF_PATTERN, 8'b0000_1011: reset pattern (MAX_LEN bits, LSB-aligned)
- DEF_LEN, 4: reset pattern length
- DEF_OVERLAP, 1: reset overlap mode

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  serial data bit
- cfg_load  in  1  one-cycle pulse; latch cfg_* and restart detection
- cfg_pattern  in  MAX_LEN  pattern; bit len-1 = first bit received, bit 0 = last
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length, 1..MAX_LEN; 0 disables matching
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- cnt_clr  in  1  synchronous clear of match_count
- match  out  1  Mealy match, combinational, same cycle as the final pattern bit
- match_q  out  1  match registered one cycle later
- match_count  out  CNT_W  saturating count of matches
- cnt_sat  out  1  match_count is all-ones

## Operation
- State: the history shift register hist[MAX_LEN-1:0] (hist[0] holds the newest bit), the fill counter fill (0..MAX_LEN, saturating) and the latched pattern, len and overlap.
- Accepted bit: a bit is accepted when in_valid=1 and cfg_load=0.
- Window: win = {hist[MAX_LEN-2:0], in_bit}.
- Match condition: match = accepted && len≠0 && fill ≥ len-1 && win[len-1:0] == pattern[len-1:0].
- match is 0 whenever no bit is accepted.
- On an accepted bit, hist shifts left and in_bit enters at hist[0].
- fill update on an accepted bit:
  - overlap=1, or no match: fill = min(fill+1, MAX_LEN).
  - overlap=0 and match: fill = 0, so the matched bits cannot be reused.
- Idle cycles: if in_valid=0, hist, fill and match hold.
- cfg_load: latches cfg_pattern, cfg_len and cfg_overlap, and sets fill=0. hist contents become don't-care.
- cfg_load does not affect match_count.
- cfg_load with in_valid=1 in the same cycle: configuration wins, in_bit is dropped and match=0.
- cfg_len > MAX_LEN is treated as len=0 (disabled).
- match_count:
  - +1 on match, saturating at 2^CNT_W-1.
  - cnt_clr has priority: if cnt_clr and match occur in the same cycle, the result is 0.
- Reset values: hist=0, fill=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, match_q=0, match_count=0, cnt_sat=0.
- match is 0 while rst is asserted.
- Reset mid-stream discards any partial pattern. No match is possible until len bits have been accepted after reset.

## Timing
- match: zero latency, valid in the same cycle as the last pattern bit.
- match_q: one cycle after match.
- match_count and cnt_sat: updated at the clock edge ending the match cycle, so they are visible one cycle after match.
- cfg_load: takes effect for the bit accepted in the next cycle.
- Earliest match after cfg_load or reset: on the len-th accepted bit.
- Gaps: in_valid gaps of any length do not break a pattern in progress.
- Single clock domain. All inputs are synchronous to clk except rst.

## Structure
- seq_det_pkg holds the default MAX_LEN, DEF_PATTERN, DEF_LEN, DEF_OVERLAP and the width helper for cfg_len/fill.
- One sub-module, seq_det_match_cnt: saturating counter with synchronous clear, increment input, count and sat outputs.
- The history/fill/compare logic stays in the top module.

## Test plan
- Defaults, stream 1011011: match in the cycles of bits 4 and 7; match_count=2; match_q follows match by one cycle.
- cfg_load with pattern 1011, len 4, overlap 0; stream 10110111011: match on bits 4 and 11 only (the overlap candidate at bit 7 is suppressed).
- len=1, pattern 1, stream 0110 with idle gaps: match on every accepted 1. Idle cycles give match=0 with state unchanged.
- MAX_LEN=8, pattern 10000001, len 8: match only after 8 accepted bits. cfg_load mid-pattern, then the remaining bits: no match.
- CNT_W=2, six matches: count runs 1,2,3,3,3,3 with cnt_sat=1 from the third match. cnt_clr in the same cycle as a match gives 0.
- Assert rst during the bit-3 cycle of 1011: all outputs return to reset values. A fresh 1011 afterwards matches on its 4th bit. cfg_len=0 yields no matches on any stream.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared defaults and helpers for the parametrised serial pattern detector.
//   Holds the default pattern geometry (1011, length 4, overlapping) and the
//   width helper used to size cfg_len and the fill counter.
package seq_det_pkg;

    localparam int unsigned PKG_MAX_LEN     = 8;
    localparam int unsigned PKG_CNT_W       = 16;
    localparam logic [7:0]  PKG_DEF_PATTERN = 8'b0000_1011;
    localparam int unsigned PKG_DEF_LEN     = 4;
    localparam bit          PKG_DEF_OVERLAP = 1'b1;

    // Bits needed to hold a length value in 0..max_len inclusive.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// seq_det_match_cnt
//   Saturating event counter with synchronous clear.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   i_clr    synchronous clear, wins over i_inc
//   i_inc    count one event this cycle
//   o_count  current count, sticks at all-ones
//   o_sat    o_count is all-ones
module seq_det_match_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat
);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat = &r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_sat   = w_sat;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial bit-pattern detector with runtime-loadable pattern, length and
//   overlap mode. Mealy match output plus a registered copy and a saturating
//   match counter.
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   in_valid     in_bit is valid this cycle
//   in_bit       serial data bit
//   cfg_load     one-cycle pulse: latch cfg_* and restart detection
//   cfg_pattern  pattern; bit len-1 is the first bit received, bit 0 the last
//   cfg_len      pattern length 1..MAX_LEN; 0 or >MAX_LEN disables matching
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   cnt_clr      synchronous clear of match_count (wins over a match)
//   match        combinational match in the cycle of the final pattern bit
//   match_q      match delayed by one cycle
//   match_count  saturating number of matches
//   cnt_sat      match_count is all-ones
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned         MAX_LEN     = PKG_MAX_LEN,
    parameter int unsigned         CNT_W       = PKG_CNT_W,
    parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(PKG_DEF_PATTERN),
    parameter int unsigned         DEF_LEN     = PKG_DEF_LEN,
    parameter bit                  DEF_OVERLAP = PKG_DEF_OVERLAP,
    localparam int unsigned        LW          = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat
);

    // Out-of-range lengths collapse to 0, which disables matching.
    function automatic logic [LW-1:0] sane_len(input logic [31:0] l);
        return (l > MAX_LEN) ? '0 : LW'(l);
    endfunction

    // The oldest history bit never reaches the compare window, so only
    // MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0] r_hist;
    logic [LW-1:0]      r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LW-1:0]      r_len;
    logic               r_overlap;
    logic               r_match_q;

    logic               w_accept;
    logic [MAX_LEN-1:0] w_win;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_cmp;
    logic               w_fill_ok;
    logic               w_match;
    logic [LW-1:0]      w_fill_inc;

    assign w_accept = in_valid & ~cfg_load;
    assign w_win    = {r_hist, in_bit};

    // Only the low r_len bits of the window take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < 32'(r_len));
        end
    end

    assign w_cmp = (((w_win ^ r_pattern) & w_mask) == '0);

    // fill >= len-1, evaluated one bit wider so fill+1 cannot wrap.
    assign w_fill_ok = (({1'b0, r_fill} + (LW+1)'(1)) >= {1'b0, r_len});

    // rst gating keeps match low while reset is held, whatever the defaults.
    assign w_match = rst & w_accept & (r_len != '0) & w_fill_ok & w_cmp;

    assign w_fill_inc = (32'(r_fill) >= MAX_LEN) ? r_fill : r_fill + LW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= DEF_PATTERN;
            r_len     <= sane_len(32'(DEF_LEN));
            r_overlap <= DEF_OVERLAP;
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
            if (cfg_load) begin
                // Any in_bit presented alongside cfg_load is dropped.
                r_pattern <= cfg_pattern;
                r_len     <= sane_len(32'(cfg_len));
                r_overlap <= cfg_overlap;
                r_fill    <= '0;
            end else if (in_valid) begin
                r_hist <= w_win[MAX_LEN-2:0];
                // Non-overlapping: a match consumes its bits.
                r_fill <= (!r_overlap && w_match) ? '0 : w_fill_inc;
            end
        end
    end

    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (cnt_clr),
        .i_inc   (w_match),
        .o_count (match_count),
        .o_sat   (cnt_sat)
    );

    assign match   = w_match;
    assign match_q = r_match_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LW      = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               match;
    logic               match_q;
    logic [15:0]        match_count;
    logic               cnt_sat;
    logic               match2;
    logic               match_q2;
    logic [1:0]         match_count2;
    logic               cnt_sat2;

    int checks   = 0;
    int failures = 0;

    seq_detector_param u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_q     (match_q),
        .match_count (match_count),
        .cnt_sat     (cnt_sat)
    );

    // Narrow-counter instance sharing the same stimulus.
    seq_detector_param #(
        .CNT_W (2)
    ) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match2),
        .match_q     (match_q2),
        .match_count (match_count2),
        .cnt_sat     (cnt_sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive n bits MSB-first; exp gives the required match per bit (same order).
    task automatic send_bits(input logic [15:0] bits, input int n, input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[n-1-i];
            @(negedge clk);
            chk("match", {31'd0, match}, {31'd0, exp[n-1-i]});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_match", {31'd0, match}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // A valid bit rides along with every load to confirm it is dropped.
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        @(negedge clk);
        chk("load_match", {31'd0, match}, 32'd0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_match_q", {31'd0, match_q}, 32'd0);
        chk("rst_count", {16'd0, match_count}, 32'd0);
        chk("rst_sat", {31'd0, cnt_sat}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Defaults: 1011 overlapping, stream 1011011
        send_bits(16'b1011, 4, 16'b0001);
        chk("t1_mq_b4", {31'd0, match_q}, 32'd1);
        chk("t1_cnt_b4", {16'd0, match_count}, 32'd1);
        send_bits(16'b0, 1, 16'b0);
        chk("t1_mq_b5", {31'd0, match_q}, 32'd0);
        send_bits(16'b11, 2, 16'b01);
        chk("t1_mq_b7", {31'd0, match_q}, 32'd1);
        chk("t1_cnt", {16'd0, match_count}, 32'd2);

        // Non-overlapping 1011, stream 10110111011
        load(8'b1011, 4'd4, 1'b0);
        chk("t2_cnt_kept", {16'd0, match_count}, 32'd2);
        send_bits(16'b101_1011_1011, 11, 16'b000_1000_0001);
        chk("t2_cnt", {16'd0, match_count}, 32'd4);

        // len=1, pattern 1, stream 0110 with gaps
        load(8'b1, 4'd1, 1'b1);
        send_bits(16'b0, 1, 16'b0);
        idle();
        chk("t3_mq_idle", {31'd0, match_q}, 32'd0);
        send_bits(16'b1, 1, 16'b1);
        idle();
        idle();
        chk("t3_cnt_idle", {16'd0, match_count}, 32'd5);
        send_bits(16'b10, 2, 16'b10);
        chk("t3_cnt", {16'd0, match_count}, 32'd6);

        // 8-bit pattern 10000001 with a gap, then load mid-pattern
        load(8'b1000_0001, 4'd8, 1'b1);
        send_bits(16'b1000, 4, 16'b0);
        idle();
        send_bits(16'b0001, 4, 16'b0001);
        chk("t4_cnt", {16'd0, match_count}, 32'd7);
        send_bits(16'b1000, 4, 16'b0);
        load(8'b1000_0001, 4'd8, 1'b1);
        send_bits(16'b0001, 4, 16'b0);
        chk("t4_cnt_after_reload", {16'd0, match_count}, 32'd7);

        // Saturation on the 2-bit counter instance
        load(8'b1, 4'd1, 1'b1);
        cnt_clr = 1'b1;
        idle();
        cnt_clr = 1'b0;
        chk("t5_clr_cnt2", {30'd0, match_count2}, 32'd0);
        chk("t5_clr_sat2", {31'd0, cnt_sat2}, 32'd0);
        chk("t5_clr_cnt", {16'd0, match_count}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            send_bits(16'b1, 1, 16'b1);
            chk("t5_cnt2", {30'd0, match_count2}, (k > 3) ? 32'd3 : 32'(k));
            chk("t5_sat2", {31'd0, cnt_sat2}, (k >= 3) ? 32'd1 : 32'd0);
        end
        chk("t5_mq2", {31'd0, match_q2}, 32'd1);
        chk("t5_cnt", {16'd0, match_count}, 32'd6);
        cnt_clr  = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(negedge clk);
        chk("t5_match2_clr", {31'd0, match2}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        chk("t5_clr_match_cnt2", {30'd0, match_count2}, 32'd0);
        chk("t5_clr_match_sat2", {31'd0, cnt_sat2}, 32'd0);
        chk("t5_clr_match_cnt", {16'd0, match_count}, 32'd0);

        // Reset during the third bit of 1011
        load(8'b1011, 4'd4, 1'b1);
        send_bits(16'b1011, 4, 16'b0001);
        chk("t6_cnt_pre", {16'd0, match_count}, 32'd1);
        send_bits(16'b10, 2, 16'b00);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        rst      = 1'b0;
        @(negedge clk);
        chk("t6_rst_match", {31'd0, match}, 32'd0);
        chk("t6_rst_mq", {31'd0, match_q}, 32'd0);
        chk("t6_rst_cnt", {16'd0, match_count}, 32'd0);
        chk("t6_rst_sat", {31'd0, cnt_sat}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        send_bits(16'b1011, 4, 16'b0001);
        chk("t6_fresh_mq", {31'd0, match_q}, 32'd1);
        chk("t6_fresh_cnt", {16'd0, match_count}, 32'd1);

        // Disabled lengths: 0 and out of range
        load(8'b1011, 4'd0, 1'b1);
        send_bits(16'b1011_1011, 8, 16'b0);
        load(8'hFF, 4'd9, 1'b1);
        send_bits(16'b1111, 4, 16'b0);
        chk("t7_cnt", {16'd0, match_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
